uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
// Buffered 8N1 UART transmitter: bytes written into an internal FIFO are serialised onto tx.
// Frames go out back-to-back without per-byte handshaking by the producer.
// Sits between a byte producer (CPU/bridge logic) and the board TX pin.
// Line format is compatible with the team's uart_receiver at the same clks_per_bit.
// PARAMETERS
// clks_per_bit  868  clk cycles per UART bit (100 MHz / 115200 baud); legal >= 4
// fifo_addr_w   4    FIFO depth = 2**fifo_addr_w entries (16)
// stop_bits     1    number of stop bits; legal values 1 or 2
// PORTS
// clk           in   1               system clock, all logic on rising edge
// reset         in   1               asynchronous, active-low reset
// i_wr_en       in   1               write strobe; i_wr_data pushed when fifo not full
// i_wr_data     in   8               byte to enqueue
// i_clr_ovf     in   1               clears o_overflow
// o_fifo_full   out  1               count == 2**fifo_addr_w
// o_fifo_empty  out  1               count == 0
// o_fifo_count  out  fifo_addr_w+1   bytes waiting (excludes the byte on the line)
// o_overflow    out  1               sticky: a write was dropped because the fifo was full
// o_busy        out  1               high in any state other than IDLE
// o_tx_done     out  1               1-cycle pulse on the last cycle of the final stop bit
// o_tx          out  1               serial line, registered, idle high
// BEHAVIOUR
// - Reset (reset=0, async): o_tx=1, o_busy=0, o_tx_done=0, o_overflow=0, count=0,
//   rd/wr pointers=0, FSM=IDLE; a frame in progress is abandoned, line returns high at once.
// - FIFO: push when i_wr_en && !o_fifo_full (full evaluated from the pre-edge count).
//   A write while full is dropped and sets o_overflow, even if a pop occurs in the same cycle.
//   A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo depth.
// - o_overflow: set by a dropped write, cleared by i_clr_ovf; set wins if both occur together.
// - FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..clks_per_bit-1;
//   bit_idx runs 0..7; stop_idx runs 0..stop_bits-1.
//   IDLE: if fifo non-empty, pop the head into shift_reg and go to START; o_tx=1.
//   START: o_tx=0 for clks_per_bit cycles, then go to DATA with bit_idx=0.
//   DATA: o_tx=shift_reg[bit_idx], LSB first, each bit clks_per_bit cycles; after bit 7 go to STOP.
//   STOP: o_tx=1 for stop_bits*clks_per_bit cycles.
//     o_tx_done pulses on the final cycle, then return to IDLE.
// - Latency: i_wr_en at edge N into an empty fifo with FSM in IDLE ->
//   count=1 after N, pop at N+1, o_tx falls after edge N+2.
// - Back-to-back frames have exactly one extra idle-high cycle between the stop bit and the next start bit.
// - Frame length = (10 + stop_bits - 1)*clks_per_bit cycles from the falling edge of the start bit to the IDLE entry.
// - Writes during transmission are legal and never corrupt the byte being shifted,
//   which is held in shift_reg, not in the fifo.
// - o_fifo_count, o_fifo_full and o_fifo_empty are registered and consistent in the same cycle.
// TESTING
// 1 reset=0 mid-frame (clks_per_bit=16) -> o_tx=1 and o_busy=0 immediately; count=0; no o_tx_done.
// 2 write 8'h75 once; loop o_tx into uart_receiver -> o_data_byte=8'h75.
//   Line pattern 0,1,0,1,0,1,1,1,0,1 at 16 cycles/bit.
// 3 burst of 16 writes 8'h00..8'h0F while idle -> all 16 received in order.
//   o_tx_done pulses 16 times; gap between frames is exactly 1 cycle.
// 4 17 writes in 17 consecutive cycles with clks_per_bit=868 -> the first byte is popped, so 16 are queued.
//   Write 18 is dropped with o_overflow=1; i_clr_ovf clears it.
// 5 with the fifo full, write and pop in the same cycle -> write dropped; count goes 16->15; o_overflow=1.
// 6 stop_bits=2, byte 8'hA5 -> stop phase holds high for 32 cycles; frame lasts 176 cycles.
//   The receiver still decodes 8'hA5.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serialiser.
// Handshake: a byte on i_wr_data is accepted on any rising edge where i_wr_en=1 and
// o_fifo_full=0 (pre-edge value); a write while full is dropped and flags o_overflow.
module uart_tx_buffered #(
    parameter int clks_per_bit = 868,
    parameter int fifo_addr_w  = 4,
    parameter int stop_bits    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_data,
    input  logic                 i_clr_ovf,
    output logic                 o_fifo_full,
    output logic                 o_fifo_empty,
    output logic [fifo_addr_w:0] o_fifo_count,
    output logic                 o_overflow,
    output logic                 o_busy,
    output logic                 o_tx_done,
    output logic                 o_tx
);

    localparam int depth  = 1 << fifo_addr_w;
    localparam int baud_w = $clog2(clks_per_bit);
    localparam logic [fifo_addr_w:0] full_count = (fifo_addr_w+1)'(depth);
    localparam logic [baud_w-1:0]    baud_max   = baud_w'(clks_per_bit - 1);
    localparam logic                 stop_max   = 1'(stop_bits - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_next;
    logic [baud_w-1:0]      baud_cnt, baud_next;
    logic [2:0]             bit_idx, bit_next;
    logic                   stop_idx, stop_next;
    logic [7:0]             shift_reg;
    logic [7:0]             mem [depth];
    logic [fifo_addr_w-1:0] wr_ptr, rd_ptr;
    logic [fifo_addr_w:0]   count_next;
    logic                   push, pop, done_next, tx_next, baud_last;

    assign push      = i_wr_en && !o_fifo_full;
    assign baud_last = (baud_cnt == baud_max);
    assign o_busy    = (state != IDLE);

    // Next-state, bit counters, pop request and next line level.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        stop_next  = stop_idx;
        pop        = 1'b0;
        done_next  = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!o_fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + baud_w'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[bit_idx];
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + baud_w'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (stop_idx == stop_max) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + baud_w'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = o_fifo_count;
        case ({push, pop})
            2'b10:   count_next = o_fifo_count + 1'b1;
            2'b01:   count_next = o_fifo_count - 1'b1;
            default: count_next = o_fifo_count;
        endcase
    end

    // FSM, serialiser and registered line outputs; reset abandons any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            stop_idx  <= stop_next;
            o_tx      <= tx_next;
            o_tx_done <= done_next;
            if (pop) shift_reg <= mem[rd_ptr];
        end
    end

    // FIFO pointers, registered count/flags and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_fifo_full  <= 1'b0;
            o_fifo_empty <= 1'b1;
            o_overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            o_fifo_count <= count_next;
            o_fifo_full  <= (count_next == full_count);
            o_fifo_empty <= (count_next == '0);
            if (i_wr_en && o_fifo_full) o_overflow <= 1'b1;
            else if (i_clr_ovf)         o_overflow <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_wr_data;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: per-cycle reference model plus directed corner cases.
module tb_uart_tx_buffered;

    localparam int CPB = 16;
    localparam int L1  = 10 * CPB;   // busy cycles per frame, one stop bit
    localparam int L2  = 11 * CPB;   // busy cycles per frame, two stop bits

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, clr_ovf = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, ovf, busy, done, tx;
    logic [4:0] count;
    logic       wr_en2 = 1'b0, clr_ovf2 = 1'b0;
    logic [7:0] wr_data2 = '0;
    logic       full2, empty2, ovf2, busy2, done2, tx2;
    logic [4:0] count2;

    int n_vec = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    uart_tx_buffered #(.clks_per_bit(CPB), .fifo_addr_w(4), .stop_bits(1)) dut (
        .clk(clk), .reset(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_clr_ovf(clr_ovf),
        .o_fifo_full(full), .o_fifo_empty(empty), .o_fifo_count(count), .o_overflow(ovf),
        .o_busy(busy), .o_tx_done(done), .o_tx(tx));

    uart_tx_buffered #(.clks_per_bit(CPB), .fifo_addr_w(4), .stop_bits(2)) dut2 (
        .clk(clk), .reset(rst_n), .i_wr_en(wr_en2), .i_wr_data(wr_data2), .i_clr_ovf(clr_ovf2),
        .o_fifo_full(full2), .o_fifo_empty(empty2), .o_fifo_count(count2), .o_overflow(ovf2),
        .o_busy(busy2), .o_tx_done(done2), .o_tx(tx2));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue, a busy countdown per frame and a sticky flag.
    logic [7:0] m_q[$];
    int         m_cnt, m_rem, m_k;
    logic [7:0] m_byte;
    logic       m_ovf, m_done;
    logic       m_full, m_pop;

    always_comb begin
        m_full = (m_cnt == 16);
        m_pop  = (m_rem == 0) && (m_cnt != 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt <= 0; m_rem <= 0; m_k <= 0; m_byte <= '0; m_ovf <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= (m_rem == 1);
            if (m_pop) begin
                m_byte <= m_q[0];
                m_q.pop_front();
                m_rem <= L1;
                m_k   <= 0;
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                m_k   <= m_k + 1;
            end
            if (wr_en && !m_full) m_q.push_back(wr_data);
            m_cnt <= m_cnt + ((wr_en && !m_full) ? 1 : 0) - (m_pop ? 1 : 0);
            if (wr_en && m_full) m_ovf <= 1'b1;
            else if (clr_ovf)    m_ovf <= 1'b0;
        end
    end

    // Line level implied by the frame in flight: start, 8 data LSB first, stop.
    function automatic logic exp_tx();
        int idx;
        if (m_rem > 0 && m_k >= 1) begin
            idx = (m_k - 1) / CPB;
            if (idx == 0) return 1'b0;
            if (idx <= 8) return m_byte[idx-1];
        end
        return 1'b1;
    endfunction

    // scoreboard: every cycle out of reset, all outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle", {count, full, empty, ovf, busy, done, tx},
                  {5'(m_cnt), m_full, (m_cnt == 0), m_ovf, (m_rem > 0), m_done, exp_tx()});
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic push_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n_done);
        bit ok = 1'b0;
        n_done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (empty && !busy) begin ok = 1'b1; break; end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic capture_frame(output logic [0:9] line);
        bit seen = 1'b0;
        line = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx) begin seen = 1'b1; break; end
        end
        check("start_timeout", 32'(seen), 32'd1);
        if (seen) begin
            repeat (CPB/2) @(negedge clk);
            line[0] = tx;
            for (int b = 1; b < 10; b++) begin
                repeat (CPB) @(negedge clk);
                line[b] = tx;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [0:9] line;
    } vec_t;

    vec_t vecs[6];
    logic [0:9]  got_line;
    logic [0:10] line2;
    int          nd, cyc;
    bit          seen;

    initial begin
        vecs[0] = '{8'h75, 10'b0101011101};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h01, 10'b0100000001};
        vecs[4] = '{8'h80, 10'b0000000011};
        vecs[5] = '{8'h3C, 10'b0001111001};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_state", {tx, busy, done, ovf, count, full, empty}, {4'b1000, 5'd0, 2'b01});
        rst_n = 1'b1;
        @(negedge clk);

        // table: single bytes, line sampled mid-bit like a receiver
        for (int i = 0; i < 6; i++) begin
            wait_idle(400, nd);
            push_byte(vecs[i].data);
            capture_frame(got_line);
            check($sformatf("line_%02h", vecs[i].data), 32'(got_line), 32'(vecs[i].line));
        end
        wait_idle(400, nd);

        // asynchronous reset in the middle of a frame
        push_byte(8'h5A);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {tx, busy, done, count, empty}, {3'b100, 5'd0, 1'b1});
        repeat (3) @(negedge clk);
        check("reset_hold_done", {tx, done}, 2'b10);
        rst_n = 1'b1;
        @(negedge clk);

        // 17 back-to-back writes: first is popped, 16 stay queued
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("fill_16", {count, full, ovf}, {5'd16, 2'b10});
        // write while full together with clear: set wins
        wr_en = 1'b1; clr_ovf = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0; clr_ovf = 1'b0;
        check("ovf_set_wins", {count, ovf}, {5'd16, 1'b1});
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clear", {count, ovf}, {5'd16, 1'b0});
        // write during the pop cycle while full: dropped, count 16 -> 15
        seen = 1'b0;
        for (int i = 0; i < 3*L1; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check("done_timeout", 32'(seen), 32'd1);
        push_byte(8'hDD);
        check("full_pop_write", {count, ovf}, {5'd15, 1'b1});
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        wait_idle(20*(L1+2), nd);

        // burst of 16 bytes while idle
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_idle(20*(L1+2), nd);
        check("burst_done_pulses", 32'(nd), 32'd16);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 40) == 0);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0; clr_ovf = 1'b0;
        wait_idle(20*(L1+2), nd);

        // two stop bits: frame length and decoded line
        wr_en2 = 1'b1; wr_data2 = 8'hA5;
        @(negedge clk);
        wr_en2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx2) begin seen = 1'b1; break; end
        end
        check("start2_timeout", 32'(seen), 32'd1);
        cyc = 1;
        line2 = '1;
        nd = 0;
        while (seen && cyc < L2 + 40) begin
            if (((cyc - 1) % CPB) == CPB/2 && ((cyc - 1) / CPB) < 11) line2[(cyc-1)/CPB] = tx2;
            if (done2) begin nd = cyc; break; end
            @(negedge clk);
            cyc++;
        end
        check("stop2_frame_len", 32'(nd), 32'(L2));
        check("stop2_line", 32'(line2), 32'(11'b01010010111));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
